// File: rtl/fpu_dispatch_pkg.sv
// Shared types for the FPU issue/writeback path: forwarding record and dispatch FSM states.
package fpu_dispatch_pkg;

  localparam int FWD_KEYW = 5;

  typedef struct packed {
    logic                enabled;
    logic                fenabled;
    logic [FWD_KEYW-1:0] key;
    logic [31:0]         value;
  } fwdregkv;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } dispatch_state_t;

endpackage

// File: rtl/fpu_dispatch.sv
// FPU dispatch: issues one FP op, waits for completion, drives writeback and forwarding records.
// Optional watchdog on the completion wait is enabled by defining FPU_TIMEOUT_EN.
//
// state | meaning
// IDLE  | ready for a decoded op
// ISSUE | start pulse to the FPU; completion seen here is stale and ignored
// WAIT  | waiting for fpu_completed (flush or watchdog abort back to IDLE)
// WB    | one-cycle writeback or address strobe; flush no longer aborts
module fpu_dispatch
  import fpu_dispatch_pkg::*;
#(
  parameter int REGW    = 5,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [REGW-1:0] req_rd,
  input  logic            req_fdst,
  input  logic            req_nowb,
  input  logic            flush,
  output logic            fpu_enabled,
  input  logic            fpu_completed,
  input  logic [31:0]     fpu_result,
  output logic            wb_valid,
  output logic            wb_fen,
  output logic [REGW-1:0] wb_rd,
  output logic [31:0]     wb_data,
  output logic            addr_valid,
  output fwdregkv         fwd1,
  output fwdregkv         fwd2,
  output logic            err_timeout
);

  dispatch_state_t state, state_nx;

  logic [REGW-1:0] rd_q;
  logic            fdst_q;
  logic            nowb_q;
  logic [31:0]     result_q;
  logic            accept;
  logic            capture;
  logic            wait_tc;
  logic            timeout_hit;
  logic            wb_cycle;
  logic            int_zero;

`ifdef FPU_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT + 1);

  logic [CNTW-1:0] wait_cnt;

  // Held at zero outside WAIT, so each WAIT visit starts counting from zero.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wait_cnt <= '0;
    end else if (state != WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + CNTW'(1);
    end
  end

  assign wait_tc     = (wait_cnt == CNTW'(TIMEOUT - 1));
  assign err_timeout = timeout_hit;
`else
  // No watchdog: WAIT holds until completion or flush; TIMEOUT is kept for a uniform parameter list.
  assign wait_tc     = (TIMEOUT < 0);
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    req_ready   = 1'b0;
    fpu_enabled = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !flush) state_nx = ISSUE;
      end
      ISSUE: begin
        fpu_enabled = 1'b1;
        state_nx    = flush ? IDLE : WAIT;
      end
      WAIT: begin
        if (flush) begin
          state_nx = IDLE;
        end else if (fpu_completed) begin
          state_nx = WB;
        end else if (wait_tc) begin
          state_nx    = IDLE;
          timeout_hit = 1'b1;
        end
      end
      WB:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign accept  = (state == IDLE) && req_valid && !flush;
  assign capture = (state == WAIT) && fpu_completed && !flush;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_q     <= '0;
      fdst_q   <= 1'b0;
      nowb_q   <= 1'b0;
      result_q <= '0;
    end else begin
      if (accept) begin
        rd_q   <= req_rd;
        fdst_q <= req_fdst;
        nowb_q <= req_nowb;
      end
      if (capture) result_q <= fpu_result;
    end
  end

  // x0 is hardwired zero, so an integer write to it is dropped; f0 is a real register.
  assign wb_cycle   = (state == WB);
  assign int_zero   = !fdst_q && (rd_q == '0);
  assign wb_valid   = wb_cycle && !nowb_q && !int_zero;
  assign wb_fen     = wb_valid && fdst_q;
  assign wb_rd      = wb_valid ? rd_q : '0;
  assign wb_data    = wb_cycle ? result_q : '0;
  assign addr_valid = wb_cycle && nowb_q;

  always_comb begin
    fwd1          = '0;
    fwd1.enabled  = wb_valid && !wb_fen;
    fwd1.fenabled = wb_valid && wb_fen;
    fwd1.key      = FWD_KEYW'(wb_rd);
    fwd1.value    = wb_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      fwd2 <= '0;
    end else begin
      fwd2 <= fwd1;
    end
  end

endmodule
